// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 scan-code display path.
//   ps2_state_t     : controller FSM states
//   PS2_EXT/PS2_BRK : extended-code and break-code prefix bytes
//   PS2_CLR_DEFAULT : default make code that clears the display (Enter)
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        BRK_EXT = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT         = 8'hE0;
    localparam logic [7:0] PS2_BRK         = 8'hF0;
    localparam logic [7:0] PS2_CLR_DEFAULT = 8'h5A;

endpackage

// File: rtl/ps2_prefix_timer.sv
// ps2_prefix_timer: watchdog for the prefix states of the shift controller.
//   clk, rst   : clock, synchronous active-high reset
//   i_run      : count while high; counter held at zero while low
//   i_restart  : reload the counter to zero (a byte arrived)
//   o_expire   : high in the cycle whose edge brings the count to TIMEOUT
module ps2_prefix_timer #(
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    input  logic i_restart,
    output logic o_expire
);

    logic [15:0] r_cnt;

    // A restart in the same cycle masks the expiry, so a byte landing on the
    // boundary edge is decoded in the old state.
    assign o_expire = i_run && !i_restart && (r_cnt == TIMEOUT - 16'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_restart || !i_run || o_expire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/ps2_shift_ctrl.sv
// ps2_shift_ctrl: sequencing controller for the 6-entry scan-code display
// shift register. Filters E0/F0 prefixes and the released-key byte after a
// break, shifts accepted make codes, clears on CLR_CODE, tracks fill level.
//   clk, rst  : clock, synchronous active-high reset
//   rx_data   : byte from PS/2 receiver, qualified by rx_valid
//   rx_valid  : one-cycle strobe
//   sh_data   : code presented to the shift register data input
//   shren     : one-cycle shift enable, one cycle after sh_data is loaded
//   clr       : one-cycle clear pulse
//   count     : filled slots, saturating at DEPTH; full = (count == DEPTH)
//   ovr       : sticky, a byte was dropped while a shift was in flight
// Optional feature macro: PS2_TYPEMATIC_FILTER_EN (drop typematic repeats).
module ps2_shift_ctrl import ps2_pkg::*; #(
    parameter int unsigned DEPTH    = 6,
    parameter logic [7:0]  CLR_CODE = PS2_CLR_DEFAULT,
    parameter logic [15:0] TIMEOUT  = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] sh_data,
    output logic       shren,
    output logic       clr,
    output logic [2:0] count,
    output logic       full,
    output logic       ovr
);

    localparam logic [2:0] W_DEPTH = 3'(DEPTH);

    ps2_state_t r_state, w_state_nxt;
    logic [7:0] r_sh_data;
    logic       r_pend;
    logic       r_shren;
    logic       r_clr;
    logic [2:0] r_count;
    logic       r_ovr;

    logic w_busy, w_accept, w_expire;
    logic w_make, w_clear, w_brk_byte, w_shift;

    // Busy from the edge that loads sh_data until shren drops.
    assign w_busy   = r_pend || r_shren;
    assign w_accept = rx_valid && !w_busy;

    ps2_prefix_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_run     (r_state != IDLE),
        .i_restart (rx_valid),
        .o_expire  (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_make      = 1'b0;
        w_clear     = 1'b0;
        w_brk_byte  = 1'b0;
        if (w_accept) begin
            unique case (r_state)
                IDLE, EXT: begin
                    if (rx_data == PS2_EXT) begin
                        w_state_nxt = EXT;
                    end else if (rx_data == PS2_BRK) begin
                        w_state_nxt = (r_state == EXT) ? BRK_EXT : BRK;
                    end else begin
                        w_state_nxt = IDLE;
                        if (rx_data == CLR_CODE) w_clear = 1'b1;
                        else                     w_make  = 1'b1;
                    end
                end
                default: begin
                    // BRK / BRK_EXT: a new prefix restarts decoding, anything
                    // else is the released key and is swallowed.
                    if (rx_data == PS2_EXT) begin
                        w_state_nxt = EXT;
                    end else if (rx_data == PS2_BRK) begin
                        w_state_nxt = BRK;
                    end else begin
                        w_state_nxt = IDLE;
                        w_brk_byte  = 1'b1;
                    end
                end
            endcase
        end else if (w_expire) begin
            w_state_nxt = IDLE;
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [8:0] r_last_make;
    logic       r_last_vld;
    logic [8:0] w_key;
    logic       w_repeat;

    // Key identity is the byte plus whether it came after E0.
    assign w_key    = {(r_state == EXT) || (r_state == BRK_EXT), rx_data};
    assign w_repeat = r_last_vld && (r_last_make == w_key);
    assign w_shift  = w_make && !w_repeat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_make <= '0;
            r_last_vld  <= 1'b0;
        end else if (w_clear || (w_brk_byte && w_repeat)) begin
            r_last_vld  <= 1'b0;
        end else if (w_shift) begin
            r_last_make <= w_key;
            r_last_vld  <= 1'b1;
        end
    end
`else
    assign w_shift = w_make;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_data <= '0;
            r_pend    <= 1'b0;
            r_shren   <= 1'b0;
            r_clr     <= 1'b0;
            r_count   <= '0;
            r_ovr     <= 1'b0;
        end else begin
            r_pend  <= w_shift;
            r_shren <= r_pend;
            r_clr   <= w_clear;
            if (w_shift) r_sh_data <= rx_data;
            // Clear and a pending shift never coincide: a clear needs an
            // accepted byte, which the busy window forbids.
            if (w_clear)
                r_count <= '0;
            else if (r_pend && (r_count != W_DEPTH))
                r_count <= r_count + 3'd1;
            if (rx_valid && w_busy) r_ovr <= 1'b1;
        end
    end

    assign sh_data = r_sh_data;
    assign shren   = r_shren;
    assign clr     = r_clr;
    assign count   = r_count;
    assign full    = (r_count == W_DEPTH);
    assign ovr     = r_ovr;

endmodule

// File: tb/tb_ps2_shift_ctrl.sv
module tb_ps2_shift_ctrl;

    localparam int         DEPTH = 6;
    localparam int         TMO   = 24;
    localparam logic [7:0] CLRC  = 8'h5A;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] sh_data;
    logic       shren, clr, full, ovr;
    logic [2:0] count;

    ps2_shift_ctrl #(.DEPTH(DEPTH), .CLR_CODE(CLRC), .TIMEOUT(16'(TMO))) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .sh_data(sh_data), .shren(shren), .clr(clr), .count(count),
        .full(full), .ovr(ovr)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // ---------------- reference model (key-event level) ----------------
    int       t        = 0;     // posedge index
    int       sh_edge  = -100;  // edge that accepted the last shift
    int       clr_edge = -100;  // edge that accepted the last clear
    int       last_rx  = 0;     // edge of the last rx_valid
    bit       pf_ext, pf_brk;   // prefixes seen so far
    int       m_cnt;
    int       m_sh;
    bit       m_ovr;
    int       lm_key;
    bit       lm_vld;
    bit       chk_en   = 1'b0;
    int       n_shren  = 0;

    function automatic bit is_repeat(input int key);
`ifdef PS2_TYPEMATIC_FILTER_EN
        return lm_vld && (lm_key == key);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        t++;
        if (rst) begin
            sh_edge = -100; clr_edge = -100; pf_ext = 0; pf_brk = 0;
            m_cnt = 0; m_sh = 0; m_ovr = 0; lm_vld = 0; lm_key = 0;
        end else begin
            if (sh_edge == t - 1 && m_cnt < DEPTH) m_cnt++;
            if (rx_valid) begin
                if (t - sh_edge == 1 || t - sh_edge == 2) begin
                    m_ovr = 1;
                end else begin
                    if ((pf_ext || pf_brk) && (t - last_rx > TMO)) begin
                        pf_ext = 0; pf_brk = 0;
                    end
                    if (rx_data == 8'hE0) begin
                        pf_ext = 1; pf_brk = 0;
                    end else if (rx_data == 8'hF0) begin
                        if (!(pf_ext && !pf_brk)) pf_ext = 0;
                        pf_brk = 1;
                    end else if (pf_brk) begin
                        if (is_repeat({23'd0, pf_ext, rx_data})) lm_vld = 0;
                        pf_ext = 0; pf_brk = 0;
                    end else if (rx_data == CLRC) begin
                        clr_edge = t; m_cnt = 0; lm_vld = 0; pf_ext = 0;
                    end else begin
                        if (!is_repeat({23'd0, pf_ext, rx_data})) begin
                            sh_edge = t; m_sh = rx_data;
                            lm_key = {23'd0, pf_ext, rx_data}; lm_vld = 1;
                        end
                        pf_ext = 0;
                    end
                end
                last_rx = t;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("sh_data", sh_data, m_sh);
            check("shren", shren, int'(sh_edge == t - 1));
            check("clr", clr, int'(clr_edge == t));
            check("count", count, m_cnt);
            check("full", full, int'(m_cnt == DEPTH));
            check("ovr", ovr, m_ovr);
        end
        if (shren) n_shren++;
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the byte is sampled on the following posedge.
    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        @(negedge clk);
        rx_valid = 1'b0; rx_data = 8'($urandom);
    endtask

    task automatic key(input logic [7:0] b);
        send(b); idle(3);
    endtask

    task automatic do_reset();
        rst = 1'b1; idle(2); rst = 1'b0;
    endtask

    logic [7:0] seq7 [7] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C};
    logic [7:0] pool [4] = '{8'h1C, 8'h32, 8'h75, 8'h21};
    int p;

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        idle(3);
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_sh_data", sh_data, 0);
        check("rst_count", count, 0);
        check("rst_flags", {shren, clr, full, ovr}, 0);

        // single make code: data first, shift one cycle later
        send(8'h1C);
        check("mk_data", sh_data, 8'h1C);
        check("mk_shren_early", shren, 0);
        idle(1);
        check("mk_shren", shren, 1);
        check("mk_count", count, 1);
        idle(1);
        check("mk_shren_fall", shren, 0);
        idle(1);

        // break pair discarded
        p = n_shren;
        key(8'hF0); key(8'h1C);
        check("brk_pulses", n_shren - p, 0);
        check("brk_count", count, 1);

        // extended make shifted, extended break discarded
        p = n_shren;
        key(8'hE0); key(8'h75);
        key(8'hE0); key(8'hF0); key(8'h75);
        check("ext_pulses", n_shren - p, 1);
        check("ext_data", sh_data, 8'h75);
        check("ext_count", count, 2);

        // saturation then clear
        p = n_shren;
        for (int i = 0; i < 7; i++) key(seq7[i]);
        check("sat_pulses", n_shren - p, 7);
        check("sat_count", count, DEPTH);
        check("sat_full", full, 1);
        send(CLRC);
        check("clr_pulse", clr, 1);
        check("clr_count", count, 0);
        check("clr_data", sh_data, 8'h3C);
        idle(1);
        check("clr_fall", clr, 0);
        check("clr_full", full, 0);
        idle(2);

        // timeout boundary: byte on the expiry edge is still the released key
        p = n_shren;
        send(8'hF0); idle(TMO - 1); key(8'h1C);
        check("tmo_edge_pulses", n_shren - p, 0);
        send(8'hF0); idle(TMO); key(8'h1C);
        check("tmo_past_pulses", n_shren - p, 1);
        check("tmo_data", sh_data, 8'h1C);

        // strobes one cycle apart: second dropped
        p = n_shren;
        send(8'h1D); send(8'h2D); idle(4);
        check("ovr_pulses", n_shren - p, 1);
        check("ovr_data", sh_data, 8'h1D);
        check("ovr_flag", ovr, 1);

        // reset mid-shift, with a simultaneous strobe
        send(8'h24);
        rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h35;
        @(negedge clk);
        rst = 1'b0; rx_valid = 1'b0;
        check("rst_mid_shren", shren, 0);
        check("rst_mid_ovr", ovr, 0);
        p = n_shren;
        idle(3);
        check("rst_mid_lost", n_shren - p, 0);

        // typematic repeats
        p = n_shren;
`ifdef PS2_TYPEMATIC_FILTER_EN
        key(8'h1C); key(8'h1C); key(8'h1C); key(8'hF0); key(8'h1C); key(8'h1C);
        check("typ_pulses", n_shren - p, 2);
`else
        key(8'h1C); key(8'h1C); key(8'h1C);
        check("typ_pulses", n_shren - p, 3);
`endif

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int r, g;
            logic [7:0] b;
            r = int'($urandom_range(0, 9));
            if (r < 2)       b = 8'hE0;
            else if (r < 4)  b = 8'hF0;
            else if (r == 4) b = CLRC;
            else             b = pool[$urandom_range(0, 3)];
            r = int'($urandom_range(0, 11));
            if (r == 0)      g = 1;
            else if (r == 1) g = 2;
            else if (r == 2) g = TMO;
            else if (r == 3) g = TMO + 1;
            else             g = int'($urandom_range(3, 6));
            idle(g - 1);
            if ($urandom_range(0, 99) == 0) do_reset();
            send(b);
        end
        idle(5);
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ps2_shift_ctrl.md
# ps2_shift_ctrl

Sequencing controller for the 6-entry scan-code display shift register. It consumes decoded bytes from the PS/2 receiver and filters out protocol prefixes (E0 extended, F0 break) and the released-key byte that follows a break. For each accepted make code it presents the code and issues a registered, glitch-free shift-enable pulse. On the clear key it issues a register clear, and it tracks how many display slots are filled.

## Interface
Parameters:
- DEPTH, 6, number of shift-register slots tracked by the fill counter
- CLR_CODE, 8'h5A, make code that clears the display (Enter)
- TIMEOUT, 16'd50000, clk cycles a prefix state may wait for its next byte before aborting to IDLE

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_data  in  8  byte from PS/2 receiver, valid with rx_valid
- rx_valid  in  1  one-cycle strobe, new byte on rx_data
- sh_data  out  8  code to shift in; drives shift-register data input
- shren  out  1  one-cycle shift pulse; drives shift-register shift enable
- clr  out  1  one-cycle clear pulse; drives shift-register reset
- count  out  3  slots filled, 0..DEPTH, saturating
- full  out  1  count == DEPTH
- ovr  out  1  sticky: byte dropped because the pipeline was busy

## Operation
- All outputs reset to 0 and the FSM resets to IDLE.
- FSM states: IDLE, EXT, BRK, BRK_EXT.
  - IDLE: E0 -> EXT; F0 -> BRK; CLR_CODE -> clear action; any other byte -> shift action.
  - EXT: F0 -> BRK_EXT; CLR_CODE -> clear; other -> shift (E0 prefix itself never shifted); return to IDLE.
  - BRK: any byte -> discarded; IDLE. BRK_EXT: any byte -> discarded; IDLE.
- A repeated E0 or F0 in a prefix state is treated as a fresh prefix: E0 -> EXT, F0 -> BRK.
- Shift action: latch byte into sh_data; pulse shren one cycle later; count increments, saturating at DEPTH.
- Clear action: pulse clr; count -> 0; sh_data unchanged; no shren.
- Timeout: a 16-bit counter runs in EXT/BRK/BRK_EXT and resets on each rx_valid. Reaching TIMEOUT forces IDLE without emitting anything.
- Busy: a shift is pending from the cycle the byte is latched until shren falls. rx_valid during this window drops the byte, sets ovr, and leaves the FSM state unchanged. ovr clears only on rst.

## Timing
- rx_valid at edge N (shift case): sh_data valid after edge N+1; shren high N+2..N+3; count updates at N+2.
- sh_data is stable for a full cycle before the shren rising edge and holds until the next shift.
- rx_valid at N (clear case): clr high N+1..N+2; count = 0 after N+1.
- Minimum accepted rx_valid spacing is 3 cycles. Closer strobes hit the busy window.
- rst asserted mid-shift: shren and clr drop at the next edge; the pending shift is lost.
- rst has priority over rx_valid in the same cycle.
- Timeout boundary: the abort takes effect on the edge where the counter reaches TIMEOUT. A byte arriving on that same edge is decoded in the old state.

## Configuration
- PS2_TYPEMATIC_FILTER_EN defined: holds last_make (8b + ext flag).
  - A make code equal to last_make is discarded (typematic repeat), with no shren and no count change.
  - A break whose following byte matches last_make clears last_make. A clear action also clears it.
- Not defined: every make code is shifted, including repeats.

## Structure
- Package ps2_pkg holds: FSM state enum, constants PS2_EXT = 8'hE0 and PS2_BRK = 8'hF0, and the default CLR_CODE.
- Sub-module ps2_prefix_timer: the loadable timeout counter with restart input and expire output.
- Controller FSM and the shift/clear pipeline stay in ps2_shift_ctrl.

## Test plan
- Reset, then byte 1C: sh_data = 1C after +1 cycle, shren one cycle at +2, count = 1.
- Sequence F0,1C: no shren, count unchanged, FSM back in IDLE.
- Sequence E0,75 then E0,F0,75: single shren with sh_data = 75; break pair fully discarded.
- Seven make codes 15,1D,24,2D,2C,35,3C then 5A: seven shren pulses, count saturates 6 with full = 1; 5A gives clr pulse, count = 0, full = 0.
- E0 then silence for TIMEOUT cycles, then 1C: FSM IDLE at expiry; 1C shifts normally. Two rx_valid 1 cycle apart: second dropped, ovr = 1.
- With PS2_TYPEMATIC_FILTER_EN: 1C,1C,1C,F0,1C,1C gives exactly two shren pulses. Without it, 1C,1C,1C gives three.
